// File: rtl/dmi_axi_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dmi_axi_arbiter
// Purpose : Round-robin share of one DMI request/response port among NumReq
//           requesters; one outstanding transaction with a response timeout.
// Rev     : 1.0
// ============================================================================

module dmi_axi_arbiter #(
   parameter int unsigned NumReq        = 2,
   parameter int unsigned AddrWidth     = 17,
   parameter int unsigned TimeoutCycles = 1024
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [NumReq-1:0]             s_req_valid_i,
   output logic [NumReq-1:0]             s_req_ready_o,
   input  logic [NumReq*AddrWidth-1:0]   s_req_addr_i,
   input  logic [NumReq*2-1:0]           s_req_op_i,
   input  logic [NumReq*32-1:0]          s_req_data_i,
   output logic [NumReq-1:0]             s_resp_valid_o,
   input  logic [NumReq-1:0]             s_resp_ready_i,
   output logic [31:0]                   s_resp_data_o,
   output logic [1:0]                    s_resp_resp_o,
   output logic                          m_req_valid_o,
   input  logic                          m_req_ready_i,
   output logic [AddrWidth-1:0]          m_req_addr_o,
   output logic [1:0]                    m_req_op_o,
   output logic [31:0]                   m_req_data_o,
   input  logic                          m_resp_valid_i,
   output logic                          m_resp_ready_o,
   input  logic [31:0]                   m_resp_data_i,
   input  logic [1:0]                    m_resp_resp_i,
   output logic                          busy_o,
   output logic                          timeout_o
);

   localparam int unsigned IDX_W   = $clog2(NumReq);
   localparam int unsigned TIMER_W = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
   localparam logic [TIMER_W-1:0] TIMER_MAX =
      (TimeoutCycles == 0) ? '0 : TIMER_W'(TimeoutCycles - 1);
   localparam logic TIMEOUT_EN = (TimeoutCycles != 0);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_ISSUE   = 3'd1;
   localparam logic [2:0] ST_WAIT    = 3'd2;
   localparam logic [2:0] ST_DELIVER = 3'd3;
   localparam logic [2:0] ST_DRAIN   = 3'd4;

   localparam logic [1:0] OP_NOP   = 2'd0;
   localparam logic [1:0] OP_READ  = 2'd1;
   localparam logic [1:0] OP_WRITE = 2'd2;

   localparam logic [1:0] RESP_OK   = 2'd0;
   localparam logic [1:0] RESP_FAIL = 2'd2;

   logic [2:0]           state_q, state_d;
   logic [IDX_W-1:0]     last_q, last_d;
   logic [IDX_W-1:0]     gnt_q, gnt_d;
   logic [AddrWidth-1:0] addr_q, addr_d;
   logic [1:0]           op_q, op_d;
   logic [31:0]          wdata_q, wdata_d;
   logic [31:0]          rdata_q, rdata_d;
   logic [1:0]           rresp_q, rresp_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic                 drain_q, drain_d;

   logic                 arb_found;
   logic [IDX_W-1:0]     arb_idx;
   logic [AddrWidth-1:0] req_addr;
   logic [1:0]           req_op;
   logic [31:0]          req_data;
   logic                 timer_expired;

   // Search starts one past the last winner so every holder is served in turn.
   always_comb begin : arb_search
      int unsigned cand;
      cand      = 0;
      arb_found = 1'b0;
      arb_idx   = '0;
      for (int unsigned k = 1; k <= NumReq; k++) begin
         cand = (32'(last_q) + k) % NumReq;
         if (!arb_found && s_req_valid_i[IDX_W'(cand)]) begin
            arb_found = 1'b1;
            arb_idx   = IDX_W'(cand);
         end
      end
   end

   assign req_addr      = s_req_addr_i[arb_idx*AddrWidth +: AddrWidth];
   assign req_op        = s_req_op_i[arb_idx*2 +: 2];
   assign req_data      = s_req_data_i[arb_idx*32 +: 32];
   assign timer_expired = TIMEOUT_EN && (timer_q == TIMER_MAX);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         last_q  <= IDX_W'(NumReq - 1);
         gnt_q   <= '0;
         addr_q  <= '0;
         op_q    <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         rresp_q <= '0;
         timer_q <= '0;
         drain_q <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         addr_q  <= addr_d;
         op_q    <= op_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         rresp_q <= rresp_d;
         timer_q <= timer_d;
         drain_q <= drain_d;
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      gnt_d   = gnt_q;
      addr_d  = addr_q;
      op_d    = op_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      rresp_d = rresp_q;
      timer_d = timer_q;
      drain_d = drain_q;
      case (state_q)
         ST_IDLE: begin
            if (arb_found) begin
               gnt_d   = arb_idx;
               last_d  = arb_idx;
               addr_d  = req_addr;
               op_d    = req_op;
               wdata_d = req_data;
               if (req_op == OP_READ || req_op == OP_WRITE) begin
                  state_d = ST_ISSUE;
               end else begin
                  // NOP and the reserved op are answered locally.
                  state_d = ST_DELIVER;
                  rdata_d = '0;
                  rresp_d = (req_op == OP_NOP) ? RESP_OK : RESP_FAIL;
               end
            end
         end
         ST_ISSUE: begin
            if (m_req_ready_i) begin
               state_d = ST_WAIT;
               timer_d = '0;
            end
         end
         ST_WAIT: begin
            if (m_resp_valid_i) begin
               state_d = ST_DELIVER;
               rdata_d = m_resp_data_i;
               rresp_d = m_resp_resp_i;
            end else if (timer_expired) begin
               state_d = ST_DELIVER;
               rdata_d = 32'hDEAD_BEEF;
               rresp_d = RESP_FAIL;
               drain_d = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_DELIVER: begin
            if (s_resp_ready_i[gnt_q]) begin
               if (drain_q) begin
                  state_d = ST_DRAIN;
                  timer_d = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_DRAIN: begin
            // A late response to the abandoned request must not reach the next owner.
            if (m_resp_valid_i || timer_expired) begin
               state_d = ST_IDLE;
               drain_d = 1'b0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      s_req_ready_o  = '0;
      s_resp_valid_o = '0;
      m_req_valid_o  = 1'b0;
      m_resp_ready_o = 1'b0;
      timeout_o      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Gated by reset so no grant is advertised while reset is held.
            if (arb_found && rst_ni) begin
               s_req_ready_o[arb_idx] = 1'b1;
            end
         end
         ST_ISSUE:   m_req_valid_o = 1'b1;
         ST_WAIT: begin
            m_resp_ready_o = 1'b1;
            timeout_o      = timer_expired && !m_resp_valid_i;
         end
         ST_DELIVER: s_resp_valid_o[gnt_q] = 1'b1;
         ST_DRAIN:   m_resp_ready_o = 1'b1;
         default: ;
      endcase
   end

   assign busy_o        = (state_q != ST_IDLE);
   assign m_req_addr_o  = addr_q;
   assign m_req_op_o    = op_q;
   assign m_req_data_o  = wdata_q;
   assign s_resp_data_o = rdata_q;
   assign s_resp_resp_o = rresp_q;

endmodule

`default_nettype wire
